cache_controller_assoc: RTL and testbench
=========================================

Name: cache_controller_assoc

Overview:
- Parametrised successor to the direct-mapped cache controller: control FSM for a WAYS-way set-associative cache with multi-word blocks.
- Owns the burst word counter and victim-way selection internally; the datapath supplies per-way hit/valid/dirty for the indexed set.
- Sits between the core-side cache request port and the higher-memory port. Supports write-back/write-allocate or write-through/no-write-allocate, chosen at elaboration.

Parameters:
- WAYS, 4, associativity; power of two, >=1. WAY_W = max(1, $clog2(WAYS)).
- WORDS_PER_BLOCK, 4, words per line = burst length; power of two, >=1. OFF_W = max(1, $clog2(WORDS_PER_BLOCK)).
- WRITE_BACK, 1, 1 = write-back + write-allocate; 0 = write-through + no-write-allocate.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  core request present; held until req_fulfilled
- req_operation  in  2  memory_operation_e: LOAD, STORE, CLFLUSH
- req_fulfilled  out  1  request completes this cycle
- way_hit  in  WAYS  valid-and-tag-match per way, indexed set
- way_valid  in  WAYS  valid bits, indexed set
- way_dirty  in  WAYS  dirty bits, indexed set
- hmem_req_valid  out  1  higher-memory request
- hmem_req_operation  out  2  LOAD or STORE
- hmem_req_fulfilled  in  1  higher memory accepted/returned one word
- miss_recovery_mode  out  1  high in every non-IDLE state
- selected_way  out  WAY_W  way the datapath reads/writes
- word_offset  out  OFF_W  burst word index
- perform_write  out  1  write the cache data array at selected_way/word_offset
- set_selected_dirty_bit, clear_selected_dirty_bit, clear_selected_valid_bit  out  1 each  status bit updates on selected_way
- finish_new_line_install  out  1  write tag, set valid on selected_way
- set_hmem_block_address  out  1  latch hmem block address
- use_victim_tag_for_hmem_block_address  out  1  with set_hmem_block_address: use the victim tag, not the request tag

Behaviour:
- Reset (reset_n = 0 at a clk edge): state = ST_IDLE, rr_ptr = 0, word_offset = 0, latched way = 0. All single-bit outputs are 0 in IDLE with req_valid = 0.
- States: ST_IDLE, ST_WRITEBACK, ST_ALLOCATE, ST_FLUSH, ST_WRITE_THROUGH.
- Hit way: the lowest set bit of way_hit. More than one bit set is illegal; the bench asserts on it.
- Victim way: the lowest-index way with way_valid = 0. If all ways are valid, the victim is rr_ptr.
- Latched way: captured in IDLE on any transition out of IDLE. selected_way equals the hit way in IDLE and the latched way in all other states.
- IDLE, LOAD hit: req_fulfilled = 1 in the same cycle (zero-wait).
- IDLE, STORE hit, WRITE_BACK = 1: req_fulfilled, perform_write and set_dirty in the same cycle.
- IDLE, STORE hit, WRITE_BACK = 0: perform_write, then go to WRITE_THROUGH. No dirty bit is set.
- IDLE, miss, victim clean (or WRITE_BACK = 0 and op = LOAD): set_hmem_block_address = 1, word_offset <= 0, go to ALLOCATE.
- IDLE, miss, victim valid and dirty: set_hmem_block_address and use_victim_tag both = 1, go to WRITEBACK.
- IDLE, STORE miss, WRITE_BACK = 0: set_hmem_block_address = 1, go to WRITE_THROUGH. No allocate.
- IDLE, CLFLUSH, absent: req_fulfilled = 1.
- IDLE, CLFLUSH, present and clean: clear_valid and req_fulfilled = 1.
- IDLE, CLFLUSH, present and dirty: set_hmem_block_address and use_victim_tag = 1, go to FLUSH.
- WRITEBACK and FLUSH (Moore): hmem_req_valid = 1, hmem_req_operation = STORE.
- ALLOCATE (Moore): hmem_req_valid = 1, hmem_req_operation = LOAD, perform_write = hmem_req_fulfilled.
- Burst counting: in any burst state, each hmem_req_fulfilled increments word_offset, wrapping to 0 after the last word. The last word is fulfilled when word_offset = WORDS_PER_BLOCK-1.
- WRITEBACK on the last word: clear_dirty, clear_valid, set_hmem_block_address (request tag), then go to ALLOCATE.
- ALLOCATE on the last word: finish_new_line_install, clear_dirty, go to IDLE. If the victim came from rr_ptr, rr_ptr <= rr_ptr+1 mod WAYS.
- ALLOCATE completion: req_fulfilled is not asserted. The request is re-evaluated as a hit in IDLE on the next cycle.
- FLUSH on the last word: clear_dirty, clear_valid, req_fulfilled, go to IDLE.
- WRITE_THROUGH: single-word STORE. Exits to IDLE with req_fulfilled on the first hmem_req_fulfilled; word_offset is unused.
- hmem_req_fulfilled is ignored in IDLE.
- Reset mid-burst: at the reset edge the FSM returns to IDLE, hmem_req_valid = 0 from that edge, and the burst is abandoned with no status-bit update.
- Illegal state: all outputs 'x.

Test Plan:
- Reset, then LOAD with way_hit = 4'b0100 -> req_fulfilled = 1 the same cycle, selected_way = 2, hmem_req_valid = 0.
- WAYS = 4, all valid, way_dirty[0] = 1, rr_ptr = 0, LOAD miss -> 4 STORE beats with word_offset 0..3, clear_dirty/clear_valid on beat 3, then 4 LOAD beats each with perform_write, finish_new_line_install on beat 3, rr_ptr = 1.
- way_valid = 4'b1011, LOAD miss -> victim way 2, straight to ALLOCATE, rr_ptr unchanged after install.
- WRITE_BACK = 0, STORE miss -> no allocate, one hmem STORE, req_fulfilled on hmem_req_fulfilled, set_dirty never asserted.
- CLFLUSH on a dirty hit in way 3 -> FLUSH, 4 STORE beats, req_fulfilled with clear_valid on beat 3.
- reset_n = 0 after beat 1 of ALLOCATE -> IDLE next cycle, word_offset = 0, no finish_new_line_install.

Source files
------------

// File: rtl/cache_controller_assoc.sv
// Control FSM for a WAYS-way set-associative cache with multi-word blocks.
// Owns the burst word counter and victim selection; the datapath reports per-way status.
module cache_controller_assoc #(
    parameter int WAYS            = 4,
    parameter int WORDS_PER_BLOCK = 4,
    parameter bit WRITE_BACK      = 1'b1,
    localparam int WAY_W          = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int OFF_W          = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [1:0]       req_operation,
    output logic             req_fulfilled,
    input  logic [WAYS-1:0]  way_hit,
    input  logic [WAYS-1:0]  way_valid,
    input  logic [WAYS-1:0]  way_dirty,
    output logic             hmem_req_valid,
    output logic [1:0]       hmem_req_operation,
    input  logic             hmem_req_fulfilled,
    output logic             miss_recovery_mode,
    output logic [WAY_W-1:0] selected_way,
    output logic [OFF_W-1:0] word_offset,
    output logic             perform_write,
    output logic             set_selected_dirty_bit,
    output logic             clear_selected_dirty_bit,
    output logic             clear_selected_valid_bit,
    output logic             finish_new_line_install,
    output logic             set_hmem_block_address,
    output logic             use_victim_tag_for_hmem_block_address
);
    typedef enum logic [1:0] {LOAD = 2'd0, STORE = 2'd1, CLFLUSH = 2'd2} memory_operation_e;
    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_WRITEBACK     = 3'd1,
        ST_ALLOCATE      = 3'd2,
        ST_FLUSH         = 3'd3,
        ST_WRITE_THROUGH = 3'd4
    } state_e;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_BLOCK - 1);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

    state_e            state_r, next_state_s;
    logic [WAY_W-1:0]  rr_ptr_r, latched_way_r, next_way_s;
    logic [OFF_W-1:0]  word_offset_r;
    logic              from_rr_r, next_from_rr_s;
    logic [WAY_W-1:0]  hit_way_s, victim_way_s;
    logic              hit_any_s, victim_from_rr_s, victim_dirty_s, last_beat_s;

    function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] vec);
        lowest_set = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = WAY_W'(i);
        end
    endfunction

    // Hit/victim resolution for the indexed set; invalid ways are filled before evicting rr_ptr.
    always_comb begin
        hit_any_s        = |way_hit;
        hit_way_s        = lowest_set(way_hit);
        victim_from_rr_s = &way_valid;
        victim_way_s     = victim_from_rr_s ? rr_ptr_r : lowest_set(~way_valid);
        victim_dirty_s   = way_valid[victim_way_s] && way_dirty[victim_way_s];
        next_way_s       = hit_any_s ? hit_way_s : victim_way_s;
        next_from_rr_s   = !hit_any_s && victim_from_rr_s;
        last_beat_s      = hmem_req_fulfilled && (word_offset_r == LAST_WORD);
    end

    // Next-state and control strobes; IDLE responds combinationally for zero-wait hits.
    always_comb begin
        next_state_s                          = state_r;
        req_fulfilled                         = 1'b0;
        hmem_req_valid                        = 1'b0;
        hmem_req_operation                    = LOAD;
        miss_recovery_mode                    = 1'b1;
        selected_way                          = latched_way_r;
        perform_write                         = 1'b0;
        set_selected_dirty_bit                = 1'b0;
        clear_selected_dirty_bit              = 1'b0;
        clear_selected_valid_bit              = 1'b0;
        finish_new_line_install               = 1'b0;
        set_hmem_block_address                = 1'b0;
        use_victim_tag_for_hmem_block_address = 1'b0;
        case (state_r)
            ST_IDLE: begin
                miss_recovery_mode = 1'b0;
                selected_way       = hit_way_s;
                if (req_valid) begin
                    case (req_operation)
                        LOAD: begin
                            if (hit_any_s) begin
                                req_fulfilled = 1'b1;
                            end else begin
                                set_hmem_block_address                = 1'b1;
                                use_victim_tag_for_hmem_block_address = WRITE_BACK && victim_dirty_s;
                                next_state_s = (WRITE_BACK && victim_dirty_s) ? ST_WRITEBACK : ST_ALLOCATE;
                            end
                        end
                        STORE: begin
                            if (hit_any_s && WRITE_BACK) begin
                                perform_write          = 1'b1;
                                req_fulfilled          = 1'b1;
                                set_selected_dirty_bit = 1'b1;
                            end else if (hit_any_s) begin
                                perform_write = 1'b1;
                                next_state_s  = ST_WRITE_THROUGH;
                            end else if (WRITE_BACK) begin
                                set_hmem_block_address                = 1'b1;
                                use_victim_tag_for_hmem_block_address = victim_dirty_s;
                                next_state_s = victim_dirty_s ? ST_WRITEBACK : ST_ALLOCATE;
                            end else begin
                                set_hmem_block_address = 1'b1;
                                next_state_s           = ST_WRITE_THROUGH;
                            end
                        end
                        CLFLUSH: begin
                            if (!hit_any_s) begin
                                req_fulfilled = 1'b1;
                            end else if (way_dirty[hit_way_s]) begin
                                set_hmem_block_address                = 1'b1;
                                use_victim_tag_for_hmem_block_address = 1'b1;
                                next_state_s                          = ST_FLUSH;
                            end else begin
                                clear_selected_valid_bit = 1'b1;
                                req_fulfilled            = 1'b1;
                            end
                        end
                        default: begin
                            next_state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                hmem_req_valid     = 1'b1;
                hmem_req_operation = STORE;
                if (last_beat_s) begin
                    clear_selected_dirty_bit = 1'b1;
                    clear_selected_valid_bit = 1'b1;
                    set_hmem_block_address   = 1'b1;
                    next_state_s             = ST_ALLOCATE;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                hmem_req_valid     = 1'b1;
                hmem_req_operation = LOAD;
                perform_write      = hmem_req_fulfilled;
                if (last_beat_s) begin
                    finish_new_line_install  = 1'b1;
                    clear_selected_dirty_bit = 1'b1;
                    next_state_s             = ST_IDLE;
                end else begin
                    next_state_s = ST_ALLOCATE;
                end
            end
            ST_FLUSH: begin
                hmem_req_valid     = 1'b1;
                hmem_req_operation = STORE;
                if (last_beat_s) begin
                    clear_selected_dirty_bit = 1'b1;
                    clear_selected_valid_bit = 1'b1;
                    req_fulfilled            = 1'b1;
                    next_state_s             = ST_IDLE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            ST_WRITE_THROUGH: begin
                hmem_req_valid     = 1'b1;
                hmem_req_operation = STORE;
                if (hmem_req_fulfilled) begin
                    req_fulfilled = 1'b1;
                    next_state_s  = ST_IDLE;
                end else begin
                    next_state_s = ST_WRITE_THROUGH;
                end
            end
            default: begin
                next_state_s                          = ST_IDLE;
                req_fulfilled                         = 1'bx;
                hmem_req_valid                        = 1'bx;
                hmem_req_operation                    = 2'bxx;
                miss_recovery_mode                    = 1'bx;
                selected_way                          = 'x;
                perform_write                         = 1'bx;
                set_selected_dirty_bit                = 1'bx;
                clear_selected_dirty_bit              = 1'bx;
                clear_selected_valid_bit              = 1'bx;
                finish_new_line_install               = 1'bx;
                set_hmem_block_address                = 1'bx;
                use_victim_tag_for_hmem_block_address = 1'bx;
            end
        endcase
    end

    // State, burst counter, latched way and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            word_offset_r <= '0;
            latched_way_r <= '0;
            from_rr_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_IDLE) begin
                if (next_state_s != ST_IDLE) begin
                    latched_way_r <= next_way_s;
                    from_rr_r     <= next_from_rr_s;
                    word_offset_r <= '0;
                end
            end else if (state_r != ST_WRITE_THROUGH && hmem_req_fulfilled) begin
                word_offset_r <= (word_offset_r == LAST_WORD) ? '0 : word_offset_r + OFF_W'(1);
            end
            // Only a round-robin eviction advances the pointer; filling an invalid way does not.
            if (state_r == ST_ALLOCATE && last_beat_s && from_rr_r) begin
                rr_ptr_r <= (rr_ptr_r == LAST_WAY) ? '0 : rr_ptr_r + WAY_W'(1);
            end
        end
    end

    assign word_offset = word_offset_r;
endmodule

// File: tb/tb_cache_controller_assoc.sv
// Scoreboard bench: a transaction-level model predicts each request's event sequence
// for a write-back and a write-through controller; a monitor compares observed events.
module tb_cache_controller_assoc;
    localparam int WAYS = 4;
    localparam int WPB  = 4;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_STORE = 2'd1, OP_CLFLUSH = 2'd2;

    typedef struct {
        bit rf, hv;
        bit [1:0] hop;
        int off, way;
        bit pw, sd, cd, cv, fin, sh, uv, mrm;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req_valid = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic hmem_ful = 1'b0;
    int cur = 0;
    logic [WAYS-1:0] way_hit, vld_m, drt_m;
    int tag [WAYS];
    int req_tag = 100;
    int rr_m = 0;
    ev_t sbq [$];
    int checks = 0, errors = 0, alloc_beats = 0;

    logic rf_o [2], hv_o [2], mrm_o [2], pw_o [2], sd_o [2], cd_o [2];
    logic cv_o [2], fin_o [2], sh_o [2], uv_o [2];
    logic [1:0] hop_o [2], sel_o [2], off_o [2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        hmem_ful = ($urandom_range(0, 2) != 0);
    end

    always_comb begin
        way_hit = '0;
        for (int i = 0; i < WAYS; i++) way_hit[i] = vld_m[i] && (tag[i] == req_tag);
    end

    cache_controller_assoc #(.WAYS(WAYS), .WORDS_PER_BLOCK(WPB), .WRITE_BACK(1'b1)) dut_wb (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid && cur == 0), .req_operation(req_op),
        .req_fulfilled(rf_o[0]), .way_hit(way_hit), .way_valid(vld_m), .way_dirty(drt_m),
        .hmem_req_valid(hv_o[0]), .hmem_req_operation(hop_o[0]), .hmem_req_fulfilled(hmem_ful),
        .miss_recovery_mode(mrm_o[0]), .selected_way(sel_o[0]), .word_offset(off_o[0]),
        .perform_write(pw_o[0]), .set_selected_dirty_bit(sd_o[0]), .clear_selected_dirty_bit(cd_o[0]),
        .clear_selected_valid_bit(cv_o[0]), .finish_new_line_install(fin_o[0]),
        .set_hmem_block_address(sh_o[0]), .use_victim_tag_for_hmem_block_address(uv_o[0]));

    cache_controller_assoc #(.WAYS(WAYS), .WORDS_PER_BLOCK(WPB), .WRITE_BACK(1'b0)) dut_wt (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid && cur == 1), .req_operation(req_op),
        .req_fulfilled(rf_o[1]), .way_hit(way_hit), .way_valid(vld_m), .way_dirty(drt_m),
        .hmem_req_valid(hv_o[1]), .hmem_req_operation(hop_o[1]), .hmem_req_fulfilled(hmem_ful),
        .miss_recovery_mode(mrm_o[1]), .selected_way(sel_o[1]), .word_offset(off_o[1]),
        .perform_write(pw_o[1]), .set_selected_dirty_bit(sd_o[1]), .clear_selected_dirty_bit(cd_o[1]),
        .clear_selected_valid_bit(cv_o[1]), .finish_new_line_install(fin_o[1]),
        .set_hmem_block_address(sh_o[1]), .use_victim_tag_for_hmem_block_address(uv_o[1]));

    function automatic ev_t mk();
        ev_t e;
        e = '{default: 0};
        e.off = -1;
        e.way = -1;
        return e;
    endfunction

    function automatic string ev_str(ev_t e);
        return $sformatf("rf=%0d hv=%0d op=%0d off=%0d way=%0d pw=%0d sd=%0d cd=%0d cv=%0d fin=%0d sh=%0d uv=%0d mrm=%0d",
                         e.rf, e.hv, e.hop, e.off, e.way, e.pw, e.sd, e.cd, e.cv, e.fin, e.sh, e.uv, e.mrm);
    endfunction

    function automatic bit ev_match(ev_t a, ev_t e);
        if (e.hv && a.hop != e.hop) return 1'b0;
        if (e.off >= 0 && a.off != e.off) return 1'b0;
        if (e.way >= 0 && a.way != e.way) return 1'b0;
        return a.rf == e.rf && a.hv == e.hv && a.pw == e.pw && a.sd == e.sd && a.cd == e.cd &&
               a.cv == e.cv && a.fin == e.fin && a.sh == e.sh && a.uv == e.uv && a.mrm == e.mrm;
    endfunction

    // kind: 0 = eviction write-back, 1 = flush, 2 = line fill
    function automatic void burst(int kind, int w);
        ev_t e;
        for (int k = 0; k < WPB; k++) begin
            e = mk();
            e.hv = 1; e.mrm = 1; e.off = k; e.way = w;
            e.hop = (kind == 2) ? OP_LOAD : OP_STORE;
            e.pw = (kind == 2);
            if (k == WPB - 1) begin
                e.cd = 1;
                e.cv = (kind != 2);
                e.fin = (kind == 2);
                e.sh = (kind == 0);
                e.rf = (kind == 1);
            end
            sbq.push_back(e);
        end
    endfunction

    function automatic void hit_ev(logic [1:0] op, bit wb, int w);
        ev_t e;
        e = mk();
        e.way = w;
        if (op == OP_LOAD) begin
            e.rf = 1;
            sbq.push_back(e);
        end else begin
            e.pw = 1; e.rf = wb; e.sd = wb;
            sbq.push_back(e);
            if (!wb) begin
                e = mk();
                e.hv = 1; e.hop = OP_STORE; e.rf = 1; e.way = w; e.mrm = 1;
                sbq.push_back(e);
            end
        end
    endfunction

    function automatic void predict(logic [1:0] op, bit wb);
        int h = -1, v = -1;
        bit from_rr = 0;
        ev_t e;
        for (int i = WAYS - 1; i >= 0; i--) if (vld_m[i] && tag[i] == req_tag) h = i;
        if (op == OP_CLFLUSH) begin
            e = mk();
            if (h < 0) begin
                e.rf = 1; sbq.push_back(e);
            end else if (!drt_m[h]) begin
                e.rf = 1; e.cv = 1; e.way = h; sbq.push_back(e);
            end else begin
                e.sh = 1; e.uv = 1; e.way = h; sbq.push_back(e);
                burst(1, h);
            end
            return;
        end
        if (h >= 0) begin
            hit_ev(op, wb, h);
            return;
        end
        for (int i = WAYS - 1; i >= 0; i--) if (!vld_m[i]) v = i;
        if (v < 0) begin v = rr_m; from_rr = 1; end
        e = mk();
        e.sh = 1;
        if (!wb && op == OP_STORE) begin
            sbq.push_back(e);
            e = mk();
            e.hv = 1; e.hop = OP_STORE; e.rf = 1; e.way = v; e.mrm = 1;
            sbq.push_back(e);
            return;
        end
        if (wb && vld_m[v] && drt_m[v]) begin
            e.uv = 1; sbq.push_back(e);
            burst(0, v);
        end else begin
            sbq.push_back(e);
        end
        burst(2, v);
        if (from_rr) rr_m = (rr_m + 1) % WAYS;
        hit_ev(op, wb, v);
    endfunction

    // Monitor: compare each observed event against the scoreboard, then apply status updates.
    always @(negedge clk) begin
        ev_t a, e;
        int s;
        if (reset_n) begin
            if (req_valid && $countones(way_hit) > 1) begin
                errors++;
                $display("FAIL multi_hit way_hit=%b", way_hit);
            end
            a = mk();
            a.rf = rf_o[cur]; a.hv = hv_o[cur]; a.hop = hop_o[cur]; a.off = int'(off_o[cur]);
            a.way = int'(sel_o[cur]); a.pw = pw_o[cur]; a.sd = sd_o[cur]; a.cd = cd_o[cur];
            a.cv = cv_o[cur]; a.fin = fin_o[cur]; a.sh = sh_o[cur]; a.uv = uv_o[cur]; a.mrm = mrm_o[cur];
            if ((a.hv && hmem_ful) || a.rf || a.pw || a.sd || a.cd || a.cv || a.fin || a.sh) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event actual %s required none", ev_str(a));
                end else begin
                    e = sbq.pop_front();
                    if (!ev_match(a, e)) begin
                        errors++;
                        $display("FAIL event actual %s required %s", ev_str(a), ev_str(e));
                    end
                    if (a.hv && a.hop == OP_LOAD) alloc_beats++;
                end
                s = a.way;
                if (a.sd) drt_m[s] = 1'b1;
                if (a.cd) drt_m[s] = 1'b0;
                if (a.cv) vld_m[s] = 1'b0;
                if (a.fin) begin vld_m[s] = 1'b1; tag[s] = req_tag; end
            end
        end
    end

    task automatic set_state(input logic [WAYS-1:0] v, input logic [WAYS-1:0] d);
        for (int i = 0; i < WAYS; i++) tag[i] = i;
        vld_m = v;
        drt_m = d;
    endtask

    task automatic rand_state(input bit wb);
        for (int i = 0; i < WAYS; i++) begin
            tag[i] = i + WAYS * $urandom_range(0, 1);
            vld_m[i] = ($urandom_range(0, 3) != 0);
            drt_m[i] = wb && vld_m[i] && ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input int t);
        bit done = 0;
        req_tag = t;
        req_op = op;
        predict(op, cur == 0);
        req_valid = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (rf_o[cur]) done = 1;
        end
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout op=%0d tag=%0d actual no_completion required completion", op, t);
            sbq.delete();
            reset_n = 1'b0;
            rr_m = 0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
        end else if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover op=%0d tag=%0d actual %0d pending required 0", op, t, sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic random_phase(input int n);
        logic [1:0] op;
        for (int r = 0; r < n; r++) begin
            if ($urandom_range(0, 3) == 0) rand_state(cur == 0);
            case ($urandom_range(0, 4))
                0, 1:    op = OP_LOAD;
                2, 3:    op = OP_STORE;
                default: op = OP_CLFLUSH;
            endcase
            do_req(op, $urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        set_state(4'b1111, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rf_o[d] || hv_o[d] || mrm_o[d] || pw_o[d] || sd_o[d] || cd_o[d] || cv_o[d] || fin_o[d] ||
                sh_o[d] || uv_o[d] || sel_o[d] != 2'd0 || off_o[d] != 2'd0) begin
                errors++;
                $display("FAIL reset_state dut=%0d actual rf=%0d hv=%0d mrm=%0d sel=%0d off=%0d required all zero",
                         d, rf_o[d], hv_o[d], mrm_o[d], sel_o[d], off_o[d]);
            end
        end
        @(posedge clk);
        #1;

        cur = 0;
        set_state(4'b1111, 4'b0000); do_req(OP_LOAD, 2);
        set_state(4'b1111, 4'b0001); do_req(OP_LOAD, 9);
        set_state(4'b1011, 4'b0000); do_req(OP_LOAD, 9);
        set_state(4'b1111, 4'b1000); do_req(OP_CLFLUSH, 3);
        do_req(OP_STORE, 1);
        do_req(OP_CLFLUSH, 1);
        do_req(OP_STORE, 12);

        // Reset in the middle of a line fill: abandoned with no install.
        set_state(4'b1111, 4'b0000);
        req_tag = 9; req_op = OP_LOAD;
        base = alloc_beats;
        predict(OP_LOAD, 1'b1);
        req_valid = 1'b1;
        for (int c = 0; c < 300 && alloc_beats < base + 2; c++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        req_valid = 1'b0;
        sbq.delete();
        rr_m = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (alloc_beats < base + 2 || mrm_o[0] || hv_o[0] || off_o[0] != 2'd0) begin
            errors++;
            $display("FAIL mid_burst_reset actual beats=%0d mrm=%0d hv=%0d off=%0d required beats>=2 mrm=0 hv=0 off=0",
                     alloc_beats - base, mrm_o[0], hv_o[0], off_o[0]);
        end
        @(posedge clk);
        #1;
        do_req(OP_LOAD, 9);
        random_phase(120);

        cur = 1;
        rr_m = 0;
        set_state(4'b1111, 4'b0000);
        do_req(OP_STORE, 9);
        do_req(OP_STORE, 1);
        do_req(OP_LOAD, 10);
        do_req(OP_LOAD, 10);
        random_phase(120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
